pin_drive_arb: RTL and testbench
================================

PIN_DRIVE_ARB -- requirements
Module: pin_drive_arb

Interface
REQ-001 SHALL have parameter NumReq, default 4: number of requesters sharing the pin bank (2..8).
REQ-002 SHALL have parameter Width, default 8: number of pins in the bank.
REQ-003 SHALL have parameter TurnCycles, default 2: hi-Z turnaround cycles between owners; must be at least 1.
REQ-004 SHALL have parameter MaxHold, default 16: grant cycles before forced revoke; 0 disables preemption.
REQ-005 SHALL have one clock; reset is asynchronous and active-low: clk_i  in  1  clock; rst_ni  in  1  async active-low reset.
REQ-006 SHALL have req_i  in  NumReq  level request per requester.
REQ-007 SHALL have drv_val_i  in  NumReq*Width  per-requester drive value.
REQ-008 SHALL have drv_en_i  in  NumReq*Width  per-requester output enable.
REQ-009 SHALL have idle_pu_i / idle_pd_i  in  Width each  pull-up / pull-down config for undriven pins.
REQ-010 SHALL have pins_i  in  Width  sampled pad value.
REQ-011 SHALL have gnt_o  out  NumReq  one-hot grant.
REQ-012 SHALL have pins_o, pins_oe_o, pins_pu_o, pins_pd_o  out  Width each  pad drive value, output enable, pull-up, pull-down.
REQ-013 SHALL have sample_o  out  Width  registered pins_i.
REQ-014 SHALL have busy_o  out  1  high in GRANT or TURN.
REQ-015 SHALL have preempt_o  out  1  one-cycle pulse on forced revoke.

Function
REQ-016 SHALL implement FSM states IDLE, GRANT, TURN.
REQ-017 IDLE: any req_i high at edge N SHALL move to GRANT with gnt_o one-hot to the winner from cycle N+1.
REQ-018 Winner SHALL be chosen round-robin, searching from pointer ptr; ptr SHALL update to (winner+1) mod NumReq on each grant.
REQ-019 GRANT: pins_oe_o = drv_en_i[owner]; pins_o = drv_val_i[owner] & drv_en_i[owner]; pins_pu_o = idle_pu_i & ~pins_oe_o; pins_pd_o = idle_pd_i & ~idle_pu_i & ~pins_oe_o.
REQ-020 IDLE/TURN: pins_oe_o = 0, pins_o = 0, pins_pu_o = idle_pu_i, pins_pd_o = idle_pd_i & ~idle_pu_i (pull-up wins).
REQ-021 GRANT: hold_cnt SHALL increment each cycle from 0; req_i[owner] low SHALL enter TURN, with gnt_o low from the next cycle.
REQ-022 GRANT, MaxHold != 0: hold_cnt == MaxHold-1 with any other req_i high SHALL enter TURN and pulse preempt_o for 1 cycle; with no other request, hold SHALL continue and hold_cnt saturate.
REQ-023 If owner release and preempt condition coincide, release SHALL take effect and preempt_o SHALL stay low.
REQ-024 TURN SHALL last exactly TurnCycles cycles with gnt_o = 0; at the last cycle it SHALL arbitrate as IDLE and go directly to GRANT if any req_i high, else IDLE.
REQ-025 A preempted owner still requesting SHALL be eligible again, subject to ptr order.
REQ-026 Requests changing during TURN SHALL not be latched; only req_i at the final TURN cycle counts.
REQ-027 sample_o SHALL register pins_i every cycle (1-cycle latency).
REQ-028 A parameter assertion SHALL fire if TurnCycles == 0 or NumReq < 2.

Reset
REQ-029 On rst_ni low, outputs SHALL be immediately: FSM = IDLE, ptr = 0, hold_cnt = 0, gnt_o = 0, pins_oe_o = 0, pins_o = 0, sample_o = 0, busy_o = 0, preempt_o = 0; pulls follow REQ-020.
REQ-030 Reset mid-GRANT SHALL drop the owner without a turnaround; first post-reset grant SHALL follow REQ-017.

Structure
REQ-031 The FSM state enum and counter-width localparams SHALL live in pin_drive_arb_pkg.
REQ-032 Round-robin selection SHALL be a combinational sub-module pin_drive_rr (req, ptr -> one-hot winner, valid).

Verification
REQ-033 Single request: req_i=4'b0010 at cycle 0 -> gnt_o=0010 at cycle 1; pins_oe_o = drv_en_i[1]; release at cycle 5 -> gnt_o=0 at 6, oe=0 for 2 cycles, IDLE at 8.
REQ-034 All request: req_i=4'b1111 from reset -> grants 0,1,2,3,0 in order, each separated by 2 zero-oe cycles.
REQ-035 Preempt: req0 held, req2 raised at grant cycle 3 -> preempt_o pulses at grant cycle 16, gnt_o=0100 after 2 TURN cycles.
REQ-036 Coincident release: owner drops req exactly at hold_cnt=15 with req1 high -> preempt_o stays 0, req1 granted.
REQ-037 Pulls: idle_pu_i=8'hF0, idle_pd_i=8'hFF, no request -> pins_pu_o=F0, pins_pd_o=0F; GRANT with drv_en=8'h3C -> pu=C0, pd=03.
REQ-038 Async reset mid-GRANT -> gnt_o and pins_oe_o reach 0 before the next clock edge; ptr returns to 0.

Source files
------------

// File: rtl/pin_drive_arb_pkg.sv
// Shared types and width helpers for the pin-bank drive arbiter.
package pin_drive_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_e;

    localparam int MinNumReq     = 2;
    localparam int MaxNumReq     = 8;
    localparam int MinTurnCycles = 1;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pin_drive_rr.sv
// Combinational round-robin pick: lowest requester at or above ptr wins, wrapping.
module pin_drive_rr
    import pin_drive_arb_pkg::*;
#(
    parameter int NumReq = 4,
    parameter int PtrW   = 2
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [PtrW-1:0]   ptr_i,
    output logic [NumReq-1:0] win_o,
    output logic              vld_o
);

    logic [NumReq-1:0] rot;
    logic [NumReq-1:0] first;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    assign rot   = NumReq'({req_i, req_i} >> ptr_i);
    assign first = rot & (~rot + NumReq'(1));
    assign win_o = NumReq'(({first, first} << ptr_i) >> NumReq);
    assign vld_o = |req_i;

endmodule

// File: rtl/pin_drive_arb.sv
// Arbitrates a shared pin bank among NumReq requesters with hi-Z turnaround and hold-time preemption.
// Grant appears one cycle after request; pad outputs are combinational from the registered owner.
module pin_drive_arb
    import pin_drive_arb_pkg::*;
#(
    parameter int NumReq     = 4,
    parameter int Width      = 8,
    parameter int TurnCycles = 2,
    parameter int MaxHold    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq-1:0]       req_i,
    input  logic [NumReq*Width-1:0] drv_val_i,
    input  logic [NumReq*Width-1:0] drv_en_i,
    input  logic [Width-1:0]        idle_pu_i,
    input  logic [Width-1:0]        idle_pd_i,
    input  logic [Width-1:0]        pins_i,
    output logic [NumReq-1:0]       gnt_o,
    output logic [Width-1:0]        pins_o,
    output logic [Width-1:0]        pins_oe_o,
    output logic [Width-1:0]        pins_pu_o,
    output logic [Width-1:0]        pins_pd_o,
    output logic [Width-1:0]        sample_o,
    output logic                    busy_o,
    output logic                    preempt_o
);

    localparam int PtrW  = cnt_width(NumReq - 1);
    localparam int HoldW = cnt_width(MaxHold);
    localparam int TurnW = cnt_width(TurnCycles - 1);

    localparam logic [PtrW-1:0]  PtrLast  = PtrW'(NumReq - 1);
    localparam logic [TurnW-1:0] TurnLast = TurnW'(TurnCycles - 1);
    // With preemption disabled the counter just parks at all-ones.
    localparam logic [HoldW-1:0] HoldLast = (MaxHold == 0) ? '1 : HoldW'(MaxHold - 1);

    if (TurnCycles < MinTurnCycles || NumReq < MinNumReq || NumReq > MaxNumReq) begin : g_param_err
        $error("pin_drive_arb: illegal parameters NumReq=%0d TurnCycles=%0d", NumReq, TurnCycles);
    end

    state_e            state_q, state_d;
    logic [PtrW-1:0]   owner_q, owner_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [TurnW-1:0]  turn_q, turn_d;
    logic [Width-1:0]  sample_q;

    logic [NumReq-1:0] win_oh;
    logic              win_vld;
    logic [PtrW-1:0]   win_idx;
    logic [NumReq-1:0] owner_oh;
    logic              own_req;
    logic              others_req;
    logic [Width-1:0]  own_en;
    logic [Width-1:0]  own_val;
    logic              granted;
    logic              grant_now;
    logic              preempt_w;

    pin_drive_rr #(
        .NumReq (NumReq),
        .PtrW   (PtrW)
    ) u_rr (
        .req_i  (req_i),
        .ptr_i  (ptr_q),
        .win_o  (win_oh),
        .vld_o  (win_vld)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (win_oh[i]) win_idx = PtrW'(i);
        end
    end

    always_comb begin
        own_en  = '0;
        own_val = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (owner_q == PtrW'(i)) begin
                own_en  = drv_en_i[i*Width +: Width];
                own_val = drv_val_i[i*Width +: Width];
            end
        end
    end

    assign owner_oh   = NumReq'(1) << owner_q;
    assign own_req    = |(req_i & owner_oh);
    assign others_req = |(req_i & ~owner_oh);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        turn_d    = turn_q;
        grant_now = 1'b0;
        preempt_w = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) grant_now = 1'b1;
            end
            ST_GRANT: begin
                // Release is checked first so a coincident drop never reports preemption.
                if (!own_req) begin
                    state_d = ST_TURN;
                    turn_d  = '0;
                end else if (MaxHold != 0 && hold_q == HoldLast && others_req) begin
                    state_d   = ST_TURN;
                    turn_d    = '0;
                    preempt_w = 1'b1;
                end else if (hold_q != HoldLast) begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            ST_TURN: begin
                if (turn_q == TurnLast) begin
                    if (win_vld) grant_now = 1'b1;
                    else         state_d   = ST_IDLE;
                end else begin
                    turn_d = turn_q + TurnW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (grant_now) begin
            state_d = ST_GRANT;
            owner_d = win_idx;
            ptr_d   = (win_idx == PtrLast) ? '0 : win_idx + PtrW'(1);
            hold_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sample_q <= '0;
        else         sample_q <= pins_i;
    end

    assign granted   = (state_q == ST_GRANT);
    assign gnt_o     = granted ? owner_oh : '0;
    assign pins_oe_o = granted ? own_en : '0;
    assign pins_o    = granted ? (own_val & own_en) : '0;
    // Pull-up has priority; no pull on any pin being actively driven.
    assign pins_pu_o = idle_pu_i & ~pins_oe_o;
    assign pins_pd_o = idle_pd_i & ~idle_pu_i & ~pins_oe_o;
    assign sample_o  = sample_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign preempt_o = preempt_w;

endmodule

// File: tb/tb_pin_drive_arb.sv
// Directed bench for pin_drive_arb: expected grant/preempt/release events are queued with their cycle, a monitor matches them.
module tb_pin_drive_arb;

    localparam int K_GNT = 0;
    localparam int K_PRE = 1;
    localparam int K_REL = 2;

    typedef struct {
        int       kind;
        int       cyc;
        logic [3:0] gnt;
        logic [7:0] oe;
        logic [7:0] po;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] drv_val;
    logic [31:0] drv_en;
    logic [7:0]  idle_pu, idle_pd, pins_in;
    logic [3:0]  gnt;
    logic [7:0]  pins_out, pins_oe, pins_pu, pins_pd, sample;
    logic        busy, preempt;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  exp_q[$];
    logic [3:0] prev_gnt = 4'b0;

    // Hand-derived per-requester enable and (value & enable) for drv_en/drv_val below.
    logic [7:0] tab_oe [4] = '{8'h11, 8'hA5, 8'h44, 8'h88};
    logic [7:0] tab_po [4] = '{8'h11, 8'h05, 8'h40, 8'h80};

    pin_drive_arb #(
        .NumReq     (4),
        .Width      (8),
        .TurnCycles (2),
        .MaxHold    (16)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .drv_val_i  (drv_val),
        .drv_en_i   (drv_en),
        .idle_pu_i  (idle_pu),
        .idle_pd_i  (idle_pd),
        .pins_i     (pins_in),
        .gnt_o      (gnt),
        .pins_o     (pins_out),
        .pins_oe_o  (pins_oe),
        .pins_pu_o  (pins_pu),
        .pins_pd_o  (pins_pd),
        .sample_o   (sample),
        .busy_o     (busy),
        .preempt_o  (preempt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input logic [3:0] g,
                           input logic [7:0] oe, input logic [7:0] po);
        ev_t e;
        e.kind = kind; e.cyc = c; e.gnt = g; e.oe = oe; e.po = po;
        exp_q.push_back(e);
    endtask

    task automatic push_gnt(input int c, input int idx);
        push_ev(K_GNT, c, 4'(1 << idx), tab_oe[idx], tab_po[idx]);
    endtask

    task automatic got(input int kind, input logic [3:0] g, input logic [7:0] oe, input logic [7:0] po);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event: unexpected kind=%0d cycle=%0d gnt=%b", kind, cyc, g);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc ||
                (kind == K_GNT && (e.gnt !== g || e.oe !== oe || e.po !== po))) begin
                bad++;
                $display("FAIL event: got kind=%0d cycle=%0d gnt=%b oe=%h po=%h, want kind=%0d cycle=%0d gnt=%b oe=%h po=%h",
                         kind, cyc, g, oe, po, e.kind, e.cyc, e.gnt, e.oe, e.po);
            end
        end
    endtask

    // Monitor: turns grant edges and preempt pulses into events.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_gnt = 4'b0;
        end else begin
            if (prev_gnt != 4'b0 && gnt == 4'b0) got(K_REL, 4'b0, 8'h0, 8'h0);
            if (gnt != 4'b0 && gnt != prev_gnt) got(K_GNT, gnt, pins_oe, pins_out);
            if (preempt) got(K_PRE, 4'b0, 8'h0, 8'h0);
            prev_gnt = gnt;
        end
    end

    task automatic wait_until(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic neg_at(input int k);
        wait_until(k);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        req   = 4'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int c;
        rst_n   = 1'b0;
        req     = 4'b0;
        drv_en  = {8'h88, 8'h44, 8'hA5, 8'h11};
        drv_val = {8'hC3, 8'hF0, 8'h0F, 8'hFF};
        idle_pu = 8'hF0;
        idle_pd = 8'hFF;
        pins_in = 8'h00;
        #2;
        chk("reset gnt", 32'(gnt), 32'h0);
        chk("reset oe", 32'(pins_oe), 32'h0);
        chk("reset pins", 32'(pins_out), 32'h0);
        chk("reset sample", 32'(sample), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset preempt", 32'(preempt), 32'h0);
        chk("reset pu", 32'(pins_pu), 32'hF0);
        chk("reset pd", 32'(pins_pd), 32'h0F);

        // Single request with release, plus sample path.
        do_reset();
        c = cyc + 1;
        wait_until(c);
        req = 4'b0010;
        pins_in = 8'h5A;
        push_gnt(c + 1, 1);
        @(negedge clk);
        chk("sample before edge", 32'(sample), 32'h00);
        neg_at(c + 1);
        chk("sample after edge", 32'(sample), 32'h5A);
        wait_until(c + 5);
        req = 4'b0;
        push_ev(K_REL, c + 6, 4'b0, 8'h0, 8'h0);
        neg_at(c + 6);
        chk("turn1 oe", 32'(pins_oe), 32'h0);
        chk("turn1 busy", 32'(busy), 32'h1);
        neg_at(c + 7);
        chk("turn2 oe", 32'(pins_oe), 32'h0);
        chk("turn2 busy", 32'(busy), 32'h1);
        neg_at(c + 8);
        chk("idle busy", 32'(busy), 32'h0);

        // Pull masking while driving.
        do_reset();
        c = cyc + 1;
        wait_until(c);
        drv_en[7:0] = 8'h3C;
        req = 4'b0001;
        push_ev(K_GNT, c + 1, 4'b0001, 8'h3C, 8'h3C);
        @(negedge clk);
        chk("idle pu", 32'(pins_pu), 32'hF0);
        chk("idle pd", 32'(pins_pd), 32'h0F);
        neg_at(c + 2);
        chk("grant pu", 32'(pins_pu), 32'hC0);
        chk("grant pd", 32'(pins_pd), 32'h03);
        wait_until(c + 3);
        req = 4'b0;
        push_ev(K_REL, c + 4, 4'b0, 8'h0, 8'h0);
        wait_until(c + 8);
        drv_en[7:0] = 8'h11;

        // All requesting: rotation 0,1,2,3,0 with 16-cycle holds and 2-cycle turns.
        do_reset();
        c = cyc + 1;
        wait_until(c);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            push_gnt(c + 1 + 18 * k, k % 4);
            if (k < 4) begin
                push_ev(K_PRE, c + 16 + 18 * k, 4'b0, 8'h0, 8'h0);
                push_ev(K_REL, c + 17 + 18 * k, 4'b0, 8'h0, 8'h0);
            end
        end
        wait_until(c + 76);
        req = 4'b0;
        push_ev(K_REL, c + 77, 4'b0, 8'h0, 8'h0);
        wait_until(c + 82);

        // Preempt by late requester, then preempted owner regains the bank.
        do_reset();
        c = cyc + 1;
        wait_until(c);
        req = 4'b0001;
        push_gnt(c + 1, 0);
        wait_until(c + 3);
        req = 4'b0101;
        push_ev(K_PRE, c + 16, 4'b0, 8'h0, 8'h0);
        push_ev(K_REL, c + 17, 4'b0, 8'h0, 8'h0);
        push_gnt(c + 19, 2);
        push_ev(K_PRE, c + 34, 4'b0, 8'h0, 8'h0);
        push_ev(K_REL, c + 35, 4'b0, 8'h0, 8'h0);
        push_gnt(c + 37, 0);
        wait_until(c + 40);
        req = 4'b0;
        push_ev(K_REL, c + 41, 4'b0, 8'h0, 8'h0);
        wait_until(c + 46);

        // Release coinciding with the preempt point.
        do_reset();
        c = cyc + 1;
        wait_until(c);
        req = 4'b0001;
        push_gnt(c + 1, 0);
        wait_until(c + 5);
        req = 4'b0011;
        wait_until(c + 16);
        req = 4'b0010;
        push_ev(K_REL, c + 17, 4'b0, 8'h0, 8'h0);
        push_gnt(c + 19, 1);
        @(negedge clk);
        chk("coincident preempt", 32'(preempt), 32'h0);
        wait_until(c + 22);
        req = 4'b0;
        push_ev(K_REL, c + 23, 4'b0, 8'h0, 8'h0);
        wait_until(c + 28);

        // Asynchronous reset while granted.
        do_reset();
        c = cyc + 1;
        wait_until(c);
        req = 4'b0010;
        push_gnt(c + 1, 1);
        neg_at(c + 3);
        #2;
        req   = 4'b0;
        rst_n = 1'b0;
        #1;
        chk("async rst gnt", 32'(gnt), 32'h0);
        chk("async rst oe", 32'(pins_oe), 32'h0);
        chk("async rst busy", 32'(busy), 32'h0);
        chk("async rst sample", 32'(sample), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        c = cyc + 1;
        wait_until(c);
        req = 4'b1010;
        push_gnt(c + 1, 1);
        wait_until(c + 4);
        req = 4'b0;
        push_ev(K_REL, c + 5, 4'b0, 8'h0, 8'h0);
        wait_until(c + 10);

        chk("events outstanding", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
